ymux_rr_reg: RTL and testbench

Parametrised successor to the team's 2:1 combinational mux (yMux2). Selects one of N W-bit input channels and registers the result, using valid/ready handshakes on the inputs and on the output. Two modes: fixed select, where the sel port chooses the channel, and round-robin arbitration across the valid channels. Intended as the channel-steering stage between producer blocks and a single downstream consumer in the datapath labs.

---
 rtl/ymux_rr_reg.sv | 95 +++++++++
 tb/tb_ymux_rr_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ymux_rr_reg.sv
// N-channel registered mux with valid/ready handshakes; fixed-select or
// round-robin arbitration feeding a single-entry output register.
module ymux_rr_reg #(
    parameter int W    = 2,
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load;
    logic            gnt_any;
    logic [SELW-1:0] gnt_idx;

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!mode) begin
            // A sel value at or beyond N matches no channel, so it never grants.
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        load     = !out_valid_q || out_ready;
        in_ready = '0;
        if (load && gnt_any && !rst) in_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = in_data[int'(gnt_idx)*W +: W];
                out_ch_d   = gnt_idx;
                // Wrap at N rather than 2^SELW so non-power-of-two N stays in range.
                if (mode) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : SELW'(int'(gnt_idx) + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ymux_rr_reg.sv
// Directed plus randomized bench for ymux_rr_reg, checked against a
// transaction-level reference model of the output register and RR pointer.
module tb_ymux_rr_reg;

    localparam int W    = 2;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    logic [3*W-1:0]  in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic [W-1:0]    out_data3;
    logic [SELW-1:0] out_ch3;
    logic            out_valid3;

    always #5 clk = ~clk;

    ymux_rr_reg #(.W(W), .N(N), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    ymux_rr_reg #(.W(W), .N(3), .SELW(SELW)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode), .sel(sel), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: contents of the output register and the RR pointer.
    int m_ptr   = 0;
    int m_data  = 0;
    int m_ch    = 0;
    bit m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        int s;
        int c;
        if (!mode) begin
            s = int'(sel);
            if (s < N && in_valid[s]) return s;
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic int chan_data(input int c);
        logic [N*W-1:0] d;
        d = in_data;
        return int'(d[c*W +: W]);
    endfunction

    // Inputs must be set before calling; returns at posedge+1.
    task automatic step(input string tag);
        int g;
        bit load;
        logic [N-1:0] er;
        #2;
        g    = model_grant();
        load = !m_valid || out_ready;
        er   = '0;
        if (!rst && load && g >= 0) er[g] = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = chan_data(g);
                m_ch    = g;
                if (mode) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(out_data),  32'(m_data));
        check({tag, ".out_ch"},    32'(out_ch),    32'(m_ch));
    endtask

    initial begin
        int exp_seq[$];
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 8'($urandom);
        out_ready = 1'b1;
        mode      = 1'b1;
        sel       = '0;
        in_valid3 = '0;
        in_data3  = 6'($urandom);

        // Reset held two cycles with all channels valid.
        step("rst0");
        step("rst1");
        check("rst.in_ready_lit", 32'(in_ready), 32'h0);
        check("rst.out_data_lit", 32'(out_data), 32'h0);
        rst = 1'b0;
        step("rr_first");
        check("rr_first.ch", 32'(out_ch), 32'd0);

        // Fixed-select sweep of sel and per-channel data.
        mode = 1'b0;
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < 4; d++) begin
                sel = SELW'(s);
                for (int c = 0; c < N; c++) in_data[c*W +: W] = W'((d + c) % 4);
                step("fixed");
                check("fixed.ch_lit", 32'(out_ch), 32'(s));
                check("fixed.data_lit", 32'(out_data), 32'((d + s) % 4));
            end
        end

        // Round-robin with everything valid, from a fresh pointer.
        rst = 1'b1; step("rr_rst"); rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; in_data = 8'b11_10_01_00;
        exp_seq = '{0, 1, 2, 3, 0, 1};
        foreach (exp_seq[i]) begin
            step("rr_all");
            check("rr_all.ch_lit", 32'(out_ch), 32'(exp_seq[i]));
            check("rr_all.data_lit", 32'(out_data), 32'(exp_seq[i]));
            check("rr_all.valid_lit", 32'(out_valid), 32'd1);
        end

        // Sparse valids; pointer is at 2 so the order is 3,1,3,1.
        in_valid = 4'b1010;
        exp_seq = '{3, 1, 3, 1};
        foreach (exp_seq[i]) begin
            step("rr_sparse");
            check("rr_sparse.ch_lit", 32'(out_ch), 32'(exp_seq[i]));
        end
        in_valid = 4'b0000;
        step("rr_idle");
        check("rr_idle.valid_lit", 32'(out_valid), 32'd0);
        in_valid = 4'b1111;
        step("rr_ptr_kept");
        check("rr_ptr_kept.ch_lit", 32'(out_ch), 32'd2);

        // Backpressure holds everything for three cycles.
        step("bp_load");
        check("bp_load.ch_lit", 32'(out_ch), 32'd3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            check("bp_hold.ch_lit", 32'(out_ch), 32'd3);
        end
        out_ready = 1'b1;
        step("bp_resume0");
        check("bp_resume0.ch_lit", 32'(out_ch), 32'd0);
        step("bp_resume1");
        check("bp_resume1.ch_lit", 32'(out_ch), 32'd1);

        // Mode switch after a grant of channel 2, then back to RR.
        step("sw_g2");
        check("sw_g2.ch_lit", 32'(out_ch), 32'd2);
        mode = 1'b0; sel = 2'd0;
        step("sw_fixed0");
        check("sw_fixed0.ch_lit", 32'(out_ch), 32'd0);
        sel = 2'd1;
        step("sw_fixed1");
        check("sw_fixed1.ch_lit", 32'(out_ch), 32'd1);
        mode = 1'b1;
        step("sw_rr");
        check("sw_rr.ch_lit", 32'(out_ch), 32'd3);

        // N=3 instance: sel=3 never grants; sel=2 does.
        mode = 1'b0; sel = 2'd3; in_valid3 = 3'b111;
        step("n3_sel3");
        check("n3_sel3.in_ready", 32'(in_ready3), 32'h0);
        check("n3_sel3.out_valid", 32'(out_valid3), 32'd0);
        sel = 2'd2;
        step("n3_sel2");
        check("n3_sel2.out_valid", 32'(out_valid3), 32'd1);
        check("n3_sel2.out_ch", 32'(out_ch3), 32'd2);
        check("n3_sel2.out_data", 32'(out_data3), 32'(in_data3[2*W +: W]));
        in_valid3 = '0;

        // Reset while stalled with valid output.
        out_ready = 1'b0;
        step("rst_stall_pre");
        check("rst_stall_pre.valid_lit", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step("rst_stall");
        check("rst_stall.valid_lit", 32'(out_valid), 32'd0);
        rst = 1'b0; out_ready = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 31) == 0);
            in_valid  = 4'($urandom);
            in_data   = 8'($urandom);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
